// File: rtl/alu_pkg.sv
// Shared ALU definitions: result width, result record layout, stat width.
// Used by the ALU test controller and the result collector.
package alu_pkg;

  localparam int ALU_W  = 7;
  localparam int STAT_W = 8;

  typedef struct packed {
    logic             cf;
    logic             gz;
    logic [ALU_W-1:0] res;
  } alu_rec_t;

  function automatic alu_rec_t mk_rec(
    input logic             cf,
    input logic             gz,
    input logic [ALU_W-1:0] res
  );
    alu_rec_t r;
    r.cf  = cf;
    r.gz  = gz;
    r.res = res;
    return r;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO: memory, read/write pointers, level.
// Ports: push_i/wdata_i write side, pop_i/rdata_o/valid_o read side, level_o.
module result_fifo #(
  parameter  int W     = 9,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          valid_o,
  output logic [LW-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          pop_ok;
  logic          push_ok;

  // Self-protecting: pop needs data, push needs room or a same-cycle pop.
  assign pop_ok  = pop_i && (level_q != '0);
  assign push_ok = push_i && ((level_q < FULL_L) || pop_ok);

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign valid_o = (level_q != '0);
  assign level_o = level_q;

endmodule

// File: rtl/alu_result_collector.sv
// Captures ALU results {cf,gz,res} into a FWFT FIFO, ready/valid output,
// plus sticky overflow and running stats (count, carries, max, sum).
module alu_result_collector
  import alu_pkg::*;
#(
  parameter  int DATA_W = ALU_W,
  parameter  int DEPTH  = 4,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_res,
  input  logic              in_gz,
  input  logic              in_cf,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W+1:0] out_data,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic [STAT_W-1:0] res_count,
  output logic [STAT_W-1:0] carry_count,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W+2:0] res_sum
);

  localparam int SW = DATA_W + 3;
  localparam logic [LW-1:0] FULL_L = LW'(DEPTH);

  logic              pop;
  logic              push;
  logic              drop;
  logic [LW-1:0]     lvl;
  logic              ovf_q,  ovf_d;
  logic [STAT_W-1:0] cnt_q,  cnt_d;
  logic [STAT_W-1:0] cc_q,   cc_d;
  logic [DATA_W-1:0] max_q,  max_d;
  logic [SW-1:0]     sum_q,  sum_d;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && ((lvl < FULL_L) || pop);
  assign drop = in_valid && !push;

  result_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({in_cf, in_gz, in_res}),
    .pop_i   (pop),
    .rdata_o (out_data),
    .valid_o (out_valid),
    .level_o (lvl)
  );

  always_comb begin
    ovf_d = ovf_q | drop;
    cnt_d = cnt_q;
    cc_d  = cc_q;
    max_d = max_q;
    sum_d = sum_q;
    if (push) begin
      if (cnt_q != '1)         cnt_d = cnt_q + STAT_W'(1);
      if (in_cf && cc_q != '1) cc_d  = cc_q + STAT_W'(1);
      if (in_res > max_q)      max_d = in_res;
      sum_d = sum_q + SW'(in_res);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
      cc_q  <= '0;
      max_q <= '0;
      sum_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      cc_q  <= cc_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign level       = lvl;
  assign overflow    = ovf_q;
  assign res_count   = cnt_q;
  assign carry_count = cc_q;
  assign res_max     = max_q;
  assign res_sum     = sum_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed + random bench for alu_result_collector.
// Queue-based reference model; immediate assertions at each check.
module tb_alu_result_collector;
  import alu_pkg::*;

  localparam int DW    = ALU_W;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_res = '0;
  logic          in_gz = 1'b0;
  logic          in_cf = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW+1:0] out_data;
  logic [LW-1:0] level;
  logic          overflow;
  logic [7:0]    res_count;
  logic [7:0]    carry_count;
  logic [DW-1:0] res_max;
  logic [DW+2:0] res_sum;

  always #5 clk = ~clk;

  alu_result_collector #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_res      (in_res),
    .in_gz       (in_gz),
    .in_cf       (in_cf),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .level       (level),
    .overflow    (overflow),
    .res_count   (res_count),
    .carry_count (carry_count),
    .res_max     (res_max),
    .res_sum     (res_sum)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW+1:0] mq[$];
  int m_ovf, m_cnt, m_cc, m_max, m_sum;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_cnt = 0;
    m_cc  = 0;
    m_max = 0;
    m_sum = 0;
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0)
      chk({tag, ".data"}, 32'(out_data), 32'(mq[0]));
    chk({tag, ".level"}, 32'(level), 32'(mq.size()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".cnt"}, 32'(res_count), 32'(m_cnt));
    chk({tag, ".cc"}, 32'(carry_count), 32'(m_cc));
    chk({tag, ".max"}, 32'(res_max), 32'(m_max));
    chk({tag, ".sum"}, 32'(res_sum), 32'(m_sum));
  endtask

  task automatic step(string tag, bit v, int r, bit g, bit c, bit rdy);
    bit pop, push;
    in_valid  = v;
    in_res    = DW'(r);
    in_gz     = g;
    in_cf     = c;
    out_ready = rdy;
    pop  = rdy && (mq.size() > 0);
    push = v && ((mq.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back({c, g, DW'(r)});
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (c) m_cc = (m_cc < 255) ? m_cc + 1 : 255;
      if ((r % 128) > m_max) m_max = r % 128;
      m_sum = (m_sum + (r % 128)) % 1024;
    end else if (v) begin
      m_ovf = 1;
    end
    chk_all(tag);
  endtask

  task automatic async_reset(string tag);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Power-on reset
    @(negedge clk);
    @(negedge clk);
    chk_all("reset");
    rst_n = 1'b1;

    // Single push 127, gz=1, cf=0
    step("single", 1, 127, 1, 0, 0);
    chk("single.data9", 32'(out_data), 32'h0FF);
    chk("single.lvl1", 32'(level), 32'd1);
    chk("single.sum", 32'(res_sum), 32'd127);
    chk("single.max", 32'(res_max), 32'd127);
    step("single.drain", 0, 0, 0, 0, 1);

    // Fill 3, then reset between edges
    for (int i = 0; i < 3; i++) step("fill3", 1, 3 + i, 0, 1, 0);
    chk("fill3.lvl", 32'(level), 32'd3);
    async_reset("midrst");
    chk("midrst.valid0", 32'(out_valid), 32'd0);

    // Overfill with out_ready low
    for (int i = 1; i <= 5; i++) step("overfill", 1, 10 * i, 1, 0, 0);
    chk("overfill.lvl", 32'(level), 32'd4);
    chk("overfill.ovf", 32'(overflow), 32'd1);
    chk("overfill.cnt", 32'(res_count), 32'd4);
    chk("overfill.sum", 32'(res_sum), 32'd100);
    chk("overfill.max", 32'(res_max), 32'd40);

    // Full with simultaneous push(60) and pop
    chk("fullpp.head", 32'(out_data[DW-1:0]), 32'd10);
    step("fullpp", 1, 60, 1, 0, 1);
    chk("fullpp.lvl", 32'(level), 32'd4);
    begin
      int exp_d[4] = '{20, 30, 40, 60};
      for (int i = 0; i < 4; i++) begin
        chk("drain.val", 32'(out_data[DW-1:0]), 32'(exp_d[i]));
        step("drain", 0, 0, 0, 0, 1);
      end
    end
    chk("drain.empty", 32'(out_valid), 32'd0);

    // Pointer wrap: push 1..10, out_ready alternating
    async_reset("rst2");
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1)
        chk("wrap.order", 32'(out_data[DW-1:0]), 32'((i + 1) / 2));
      step("wrap", (i % 2) == 0, i / 2 + 1, 0, 0, (i % 2) == 1);
    end
    chk("wrap.noovf", 32'(overflow), 32'd0);

    // Saturation and sum wrap
    async_reset("rst3");
    for (int i = 0; i < 300; i++) step("sat", 1, 5, 0, 1, 1);
    chk("sat.cnt", 32'(res_count), 32'd255);
    chk("sat.cc", 32'(carry_count), 32'd255);
    chk("sat.sum", 32'(res_sum), 32'd476);
    chk("sat.ovf", 32'(overflow), 32'd0);

    // Random traffic against the model
    async_reset("rst4");
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset("rndrst");
      step("rnd", $urandom_range(0, 3) != 0, int'($urandom_range(0, 127)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
